// File: rtl/scramble_pkg.sv
// Shared types and default constants for the BT.656 scrambling control blocks.
package scramble_pkg;

    localparam int KEY_W_DEFAULT          = 32;
    localparam int FIELDS_PER_KEY_DEFAULT = 2;
    localparam int MAX_LINES_DEFAULT      = 244;

    // Field-level state of the scrambling scheduler.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,  // no key committed since reset
        BLANK    = 2'd1,  // vertical blanking, waiting for the next field start
        ACTIVE   = 2'd2,  // scrambling active lines
        DONE     = 2'd3   // all scrambled lines of this field have been seen
    } state_t;

endpackage

// File: rtl/bt656_edge_detect.sv
// Registers the BT.656 H/V flags and produces one-cycle edge pulses.
// The first clock after reset only primes the history registers, so a
// flag that is already low out of reset never looks like a falling edge.
module bt656_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic h,
    input  logic v,
    output logic v_fall,
    output logic v_rise,
    output logic h_rise
);

    logic prev_h;
    logic prev_v;
    logic primed;

    // History registers plus a one-shot flag marking that the history is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_h <= 1'b0;
            prev_v <= 1'b0;
            primed <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            prev_h <= h;
            prev_v <= v;
            primed <= 1'b1;
        end
    end

    assign v_fall = primed &  prev_v & ~v;
    assign v_rise = primed & ~prev_v &  v;
    assign h_rise = primed & ~prev_h &  h;

endmodule

// File: rtl/scramble_field_scheduler.sv
// Per-field key scheduler for the BT.656 scrambler: buffers one upcoming
// key, commits or re-loads the generator seed at every field start, gates
// the generator across the active lines and counts those lines.
module scramble_field_scheduler
    import scramble_pkg::*;
#(
    parameter int KEY_W          = KEY_W_DEFAULT,
    parameter int FIELDS_PER_KEY = FIELDS_PER_KEY_DEFAULT,
    parameter int MAX_LINES      = MAX_LINES_DEFAULT,
    parameter int LINE_W         = $clog2(MAX_LINES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              H,
    input  logic              V,
    input  logic [KEY_W-1:0]  key_data,
    input  logic              key_valid,
    output logic              key_ready,
    output logic [KEY_W-1:0]  seed,
    output logic              seed_load,
    output logic              gen_enable,
    output logic              scramble_en,
    output logic [LINE_W-1:0] line_idx,
    output logic              locked,
    output logic              key_underrun,
    input  logic              underrun_clr
);

    localparam int FCNT_W = (FIELDS_PER_KEY > 1) ? $clog2(FIELDS_PER_KEY) : 1;
    localparam logic [FCNT_W-1:0] LAST_FIELD = FCNT_W'(FIELDS_PER_KEY - 1);
    localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(MAX_LINES - 1);

    state_t             state;
    state_t             state_next;

    logic [KEY_W-1:0]   shadow;
    logic               shadow_valid;
    logic [FCNT_W-1:0]  fcnt;

    logic               v_fall;
    logic               v_rise;
    logic               h_rise;

    logic               key_accept;
    logic               rekey_due;
    logic               do_commit;
    logic               do_underrun;
    logic               do_fcnt_inc;
    logic               do_load;
    logic               do_line_clr;
    logic               do_line_inc;

    bt656_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .h       (H),
        .v       (V),
        .v_fall  (v_fall),
        .v_rise  (v_rise),
        .h_rise  (h_rise)
    );

    assign key_ready  = ~shadow_valid;
    assign key_accept = key_valid & ~shadow_valid;
    assign rekey_due  = (fcnt == LAST_FIELD);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next  = state;
        do_commit   = 1'b0;
        do_underrun = 1'b0;
        do_fcnt_inc = 1'b0;
        do_load     = 1'b0;
        do_line_clr = 1'b0;
        do_line_inc = 1'b0;

        case (state)
            UNLOCKED: begin
                // Without a buffered key the field simply passes unscrambled.
                if (v_fall && shadow_valid) begin
                    do_commit   = 1'b1;
                    do_load     = 1'b1;
                    do_line_clr = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            BLANK: begin
                if (v_fall) begin
                    do_load     = 1'b1;
                    do_line_clr = 1'b1;
                    state_next  = ACTIVE;
                    if (rekey_due) begin
                        // Empty shadow: re-seed with the old key and keep
                        // the counter at "due" so the next field retries.
                        if (shadow_valid) begin
                            do_commit = 1'b1;
                        end else begin
                            do_underrun = 1'b1;
                        end
                    end else begin
                        do_fcnt_inc = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (v_rise) begin
                    state_next = BLANK;
                end else if (h_rise) begin
                    if (line_idx == LAST_LINE) begin
                        state_next = DONE;
                    end else begin
                        do_line_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                if (v_rise) begin
                    state_next = BLANK;
                end
            end
            default: begin
                state_next = UNLOCKED;
            end
        endcase
    end

    // One-deep shadow buffer: filled on handshake, emptied on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the key storage is cleared on reset so no stale key from
            // before the reset can ever reach the generator.
            shadow       <= '0;
            shadow_valid <= 1'b0;
        end else if (do_commit) begin
            shadow_valid <= 1'b0;
        end else if (key_accept) begin
            shadow       <= key_data;
            shadow_valid <= 1'b1;
        end
    end

    // Fields elapsed under the current key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt <= '0;
        end else if (do_commit) begin
            fcnt <= '0;
        end else if (do_fcnt_inc) begin
            fcnt <= fcnt + FCNT_W'(1);
        end
    end

    // Active seed and lock status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seed   <= '0;
            locked <= 1'b0;
        end else if (do_commit) begin
            seed   <= shadow;
            locked <= 1'b1;
        end
    end

    // Registered generator/scrambler controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seed_load   <= 1'b0;
            gen_enable  <= 1'b0;
            scramble_en <= 1'b0;
        end else begin
            seed_load   <= do_load;
            gen_enable  <= (state_next == ACTIVE);
            scramble_en <= (state_next == ACTIVE);
        end
    end

    // Active-line index; it holds at the last line once DONE is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_idx <= '0;
        end else if (do_line_clr) begin
            line_idx <= '0;
        end else if (do_line_inc) begin
            line_idx <= line_idx + LINE_W'(1);
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_underrun <= 1'b0;
        end else if (do_underrun) begin
            key_underrun <= 1'b1;
        end else if (underrun_clr) begin
            key_underrun <= 1'b0;
        end
    end

endmodule
